// File: rtl/control_unit_legv8.sv
// control_unit_legv8: three-cycle FETCH/DECODE/EXECUTE sequencer for the LEGv8
// datapath. Holds PC, IR and latched ALU flags. Decodes IR into the 25-bit
// control word and 64-bit constant during EXECUTE. Resolves branches at the
// end of EXECUTE. An unrecognised opcode parks the unit in HALT until reset.
module control_unit_legv8 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] imem_data,
  input  logic [3:0]  status,
  output logic [63:0] imem_addr,
  output logic [24:0] control_word,
  output logic [63:0] constant,
  output logic [3:0]  flags,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    K_NONE  = 4'd0,
    K_RTYPE = 4'd1,
    K_SHIFT = 4'd2,
    K_ITYPE = 4'd3,
    K_LDUR  = 4'd4,
    K_STUR  = 4'd5,
    K_CB    = 4'd6,
    K_BCOND = 4'd7,
    K_B     = 4'd8
  } kind_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;

  kind_t       kind_s;
  logic [4:0]  fs_s;
  logic        setf_s;
  logic [4:0]  sa_s, sb_s, da_s, cfs_s;
  logic        rw_s, mw_s, bsel_s, enm_s, ena_s;
  logic [63:0] imm_s, off_s;
  logic        take_s;
  logic [24:0] cw_s;
  logic [63:0] k_s;

  // B.cond evaluation on flags {V, C, N, Z}; codes 14 and 15 always taken.
  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
    logic v, c, n, z, gt, r;
    v  = f[3];
    c  = f[2];
    n  = f[1];
    z  = f[0];
    gt = ~z & (n == v);
    case (cond)
      4'd0:    r = z;
      4'd1:    r = ~z;
      4'd2:    r = c;
      4'd3:    r = ~c;
      4'd4:    r = n;
      4'd5:    r = ~n;
      4'd6:    r = v;
      4'd7:    r = ~v;
      4'd8:    r = c & ~z;
      4'd9:    r = ~(c & ~z);
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = gt;
      4'd13:   r = ~gt;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Classify IR by opcode, trying the longest (11-bit) patterns first.
  always_comb begin
    kind_s = K_NONE;
    fs_s   = FS_ADD;
    setf_s = 1'b0;
    case (ir_q[31:21])
      11'b10001011000: begin kind_s = K_RTYPE; fs_s = FS_ADD; end
      11'b11001011000: begin kind_s = K_RTYPE; fs_s = FS_SUB; end
      11'b10001010000: begin kind_s = K_RTYPE; fs_s = FS_AND; end
      11'b10101010000: begin kind_s = K_RTYPE; fs_s = FS_ORR; end
      11'b11001010000: begin kind_s = K_RTYPE; fs_s = FS_EOR; end
      11'b10101011000: begin kind_s = K_RTYPE; fs_s = FS_ADD; setf_s = 1'b1; end
      11'b11101011000: begin kind_s = K_RTYPE; fs_s = FS_SUB; setf_s = 1'b1; end
      11'b11010011011: begin kind_s = K_SHIFT; fs_s = FS_LSL; end
      11'b11010011010: begin kind_s = K_SHIFT; fs_s = FS_LSR; end
      11'b11111000010: kind_s = K_LDUR;
      11'b11111000000: kind_s = K_STUR;
      default: begin
        case (ir_q[31:22])
          10'b1001000100: begin kind_s = K_ITYPE; fs_s = FS_ADD; end
          10'b1011000100: begin kind_s = K_ITYPE; fs_s = FS_ADD; setf_s = 1'b1; end
          10'b1101000100: begin kind_s = K_ITYPE; fs_s = FS_SUB; end
          10'b1111000100: begin kind_s = K_ITYPE; fs_s = FS_SUB; setf_s = 1'b1; end
          10'b1001001000: begin kind_s = K_ITYPE; fs_s = FS_AND; end
          10'b1011001000: begin kind_s = K_ITYPE; fs_s = FS_ORR; end
          10'b1101001000: begin kind_s = K_ITYPE; fs_s = FS_EOR; end
          default: begin
            case (ir_q[31:24])
              8'b10110100, 8'b10110101: kind_s = K_CB;
              8'b01010100:              kind_s = K_BCOND;
              default: begin
                if (ir_q[31:26] == 6'b000101) begin
                  kind_s = K_B;
                end else begin
                  kind_s = K_NONE;
                end
              end
            endcase
          end
        endcase
      end
    endcase
  end

  // Build control fields, constant and branch outcome for the classified instruction.
  always_comb begin
    sa_s   = 5'd0;
    sb_s   = 5'd0;
    da_s   = 5'd0;
    rw_s   = 1'b0;
    mw_s   = 1'b0;
    cfs_s  = 5'd0;
    bsel_s = 1'b0;
    enm_s  = 1'b0;
    ena_s  = 1'b0;
    imm_s  = 64'd0;
    off_s  = 64'd0;
    take_s = 1'b0;
    case (kind_s)
      K_RTYPE: begin
        sa_s = ir_q[9:5]; sb_s = ir_q[20:16]; da_s = ir_q[4:0];
        rw_s = 1'b1; cfs_s = fs_s; ena_s = 1'b1;
      end
      K_SHIFT: begin
        sa_s = ir_q[9:5]; da_s = ir_q[4:0]; rw_s = 1'b1; cfs_s = fs_s;
        bsel_s = 1'b1; ena_s = 1'b1; imm_s = {58'd0, ir_q[15:10]};
      end
      K_ITYPE: begin
        sa_s = ir_q[9:5]; da_s = ir_q[4:0]; rw_s = 1'b1; cfs_s = fs_s;
        bsel_s = 1'b1; ena_s = 1'b1; imm_s = {52'd0, ir_q[21:10]};
      end
      K_LDUR: begin
        sa_s = ir_q[9:5]; da_s = ir_q[4:0]; rw_s = 1'b1; cfs_s = FS_ADD;
        bsel_s = 1'b1; enm_s = 1'b1; imm_s = {{55{ir_q[20]}}, ir_q[20:12]};
      end
      K_STUR: begin
        sa_s = ir_q[9:5]; sb_s = ir_q[4:0]; mw_s = 1'b1; cfs_s = FS_ADD;
        bsel_s = 1'b1; imm_s = {{55{ir_q[20]}}, ir_q[20:12]};
      end
      K_CB: begin
        // IR[24] separates CBNZ (1) from CBZ (0); Z comes live from the datapath.
        sa_s = ir_q[4:0]; bsel_s = 1'b1; cfs_s = FS_ADD;
        off_s  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
        take_s = ir_q[24] ? ~status[0] : status[0];
      end
      K_BCOND: begin
        off_s  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
        take_s = cond_taken(ir_q[3:0], flags_q);
      end
      K_B: begin
        off_s  = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
        take_s = 1'b1;
      end
      default: begin
        take_s = 1'b0;
      end
    endcase
  end

  // Sequencer next state, PC/IR/flag updates and ungated EXECUTE outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    cw_s    = 25'd0;
    k_s     = 64'd0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_data;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (kind_s == K_NONE) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          cw_s    = {sa_s, sb_s, da_s, rw_s, mw_s, cfs_s, bsel_s, enm_s, ena_s};
          k_s     = imm_s;
          if (take_s) begin
            pc_d = pc_q + off_s;
          end else begin
            pc_d = pc_q + 64'd4;
          end
          if (setf_s) begin
            flags_d = status;
          end else begin
            flags_d = flags_q;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Suppress all datapath writes in any cycle where reset is asserted.
  always_comb begin
    if (reset) begin
      control_word = 25'd0;
      constant     = 64'd0;
    end else begin
      control_word = cw_s;
      constant     = k_s;
    end
  end

  // State, PC, IR and flag registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= 64'd0;
      ir_q    <= 32'd0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign imem_addr = pc_q;
  assign flags     = flags_q;
  assign halted    = (state_q == S_HALT);

endmodule
